// File: rtl/seq_det_event_logger.sv
// Event logger for sequence-detector hits: timestamps each detection, tags it
// with the gap since the previous one, and queues it for a valid/ready consumer.
module seq_det_event_logger #(
    parameter int TS_W  = 16,
    parameter int GAP_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     detected,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [GAP_W-1:0]         ev_gap,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         total_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TS_W-1:0]  r_ts;
    logic [GAP_W-1:0] r_since;
    logic             r_prev_vld;
    logic [TS_W-1:0]  r_mem_ts  [DEPTH];
    logic [GAP_W-1:0] r_mem_gap [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_drop;
    logic             r_ovf;

    logic             w_event;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [GAP_W-1:0] w_gap;

    assign w_event = en & detected;
    assign w_pop   = (r_level != '0) & ev_ready;
    assign w_full  = (r_level == FULL_LVL);
    // A full FIFO still accepts when its head leaves on the same edge.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;
    assign w_gap   = r_prev_vld ? r_since : '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_since    <= '0;
            r_prev_vld <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_total    <= '0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ts[i]  <= '0;
                r_mem_gap[i] <= '0;
            end
        end else if (clear) begin
            r_ts       <= '0;
            r_since    <= '0;
            r_prev_vld <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_total    <= '0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ts[i]  <= '0;
                r_mem_gap[i] <= '0;
            end
        end else begin
            if (en) begin
                r_ts <= r_ts + TS_W'(1);
            end

            // r_since holds enabled cycles elapsed since the last event.
            if (w_event) begin
                r_since    <= GAP_W'(1);
                r_prev_vld <= 1'b1;
            end else if (en && r_since != '1) begin
                r_since <= r_since + GAP_W'(1);
            end

            if (w_event && r_total != '1) begin
                r_total <= r_total + CNT_W'(1);
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) begin
                    r_drop <= r_drop + CNT_W'(1);
                end
            end

            if (w_push) begin
                r_mem_ts[r_wr_ptr]  <= r_ts;
                r_mem_gap[r_wr_ptr] <= w_gap;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign ev_valid    = (r_level != '0);
    assign ev_ts       = r_mem_ts[r_rd_ptr];
    assign ev_gap      = r_mem_gap[r_rd_ptr];
    assign fifo_level  = r_level;
    assign total_count = r_total;
    assign drop_count  = r_drop;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed testbench for seq_det_event_logger.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_seq_det_event_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clear;
    logic        detected;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_ts;
    logic [7:0]  ev_gap;
    logic [2:0]  fifo_level;
    logic [15:0] total_count;
    logic [15:0] drop_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_event_logger #(
        .TS_W(16), .GAP_W(8), .DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .detected(detected), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ts(ev_ts), .ev_gap(ev_gap), .fifo_level(fifo_level),
        .total_count(total_count), .drop_count(drop_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0;
        detected = 1'b0; ev_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({ev_valid, ev_ts, ev_gap, fifo_level, total_count,
             drop_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0d ts=%0d gap=%0d lvl=%0d tot=%0d drop=%0d ovf=%0d required all 0",
                     ev_valid, ev_ts, ev_gap, fifo_level, total_count, drop_count, overflow);
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    // Current cycle has ts=0 on entry.
    task automatic test_basic();
        repeat (10) tick();
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd10 || ev_gap !== 8'd255) begin
            n_fail++;
            $display("FAIL t1_first got v=%0d ts=%0d gap=%0d required v=1 ts=10 gap=255",
                     ev_valid, ev_ts, ev_gap);
        end
        tick();
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_valid_one_cycle got %0d required 0", ev_valid);
        end
        repeat (3) tick();
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_no_early_valid got %0d required 0", ev_valid);
        end
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd15 || ev_gap !== 8'd5 ||
            total_count !== 16'd2) begin
            n_fail++;
            $display("FAIL t1_second got v=%0d ts=%0d gap=%0d tot=%0d required v=1 ts=15 gap=5 tot=2",
                     ev_valid, ev_ts, ev_gap, total_count);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ts  [4];
        logic [7:0]  exp_gap [4];
        exp_ts  = '{16'd0, 16'd1, 16'd2, 16'd3};
        exp_gap = '{8'd255, 8'd1, 8'd1, 8'd1};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ev_ready = 1'b0;
        detected = 1'b1;
        repeat (6) tick();
        detected = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd2 || overflow !== 1'b1 ||
            total_count !== 16'd6) begin
            n_fail++;
            $display("FAIL t2_stats got lvl=%0d drop=%0d ovf=%0d tot=%0d required lvl=4 drop=2 ovf=1 tot=6",
                     fifo_level, drop_count, overflow, total_count);
        end
        tick();
        n_checks++;
        if (ev_ts !== 16'd0 || ev_gap !== 8'd255) begin
            n_fail++;
            $display("FAIL t2_hold got ts=%0d gap=%0d required ts=0 gap=255", ev_ts, ev_gap);
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ev_valid !== 1'b1 || ev_ts !== exp_ts[i] || ev_gap !== exp_gap[i]) begin
                n_fail++;
                $display("FAIL t2_drain%0d got v=%0d ts=%0d gap=%0d required v=1 ts=%0d gap=%0d",
                         i, ev_valid, ev_ts, ev_gap, exp_ts[i], exp_gap[i]);
            end
            tick();
        end
        n_checks++;
        if (ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL t2_empty got v=%0d lvl=%0d required v=0 lvl=0", ev_valid, fifo_level);
        end
    endtask

    // Current cycle has ts=11; last event was at ts=5.
    task automatic test_full_push_pop();
        logic [15:0] exp_ts  [4];
        logic [7:0]  exp_gap [4];
        exp_ts  = '{16'd12, 16'd13, 16'd14, 16'd15};
        exp_gap = '{8'd1, 8'd1, 8'd1, 8'd1};
        ev_ready = 1'b0;
        detected = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (fifo_level !== 3'd4 || ev_ts !== 16'd11 || ev_gap !== 8'd6) begin
            n_fail++;
            $display("FAIL t3_full got lvl=%0d ts=%0d gap=%0d required lvl=4 ts=11 gap=6",
                     fifo_level, ev_ts, ev_gap);
        end
        ev_ready = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd2 || total_count !== 16'd11) begin
            n_fail++;
            $display("FAIL t3_level got lvl=%0d drop=%0d tot=%0d required lvl=4 drop=2 tot=11",
                     fifo_level, drop_count, total_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ev_valid !== 1'b1 || ev_ts !== exp_ts[i] || ev_gap !== exp_gap[i]) begin
                n_fail++;
                $display("FAIL t3_drain%0d got v=%0d ts=%0d gap=%0d required v=1 ts=%0d gap=%0d",
                         i, ev_valid, ev_ts, ev_gap, exp_ts[i], exp_gap[i]);
            end
            tick();
        end
        n_checks++;
        if (ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_empty got %0d required 0", ev_valid);
        end
    endtask

    task automatic test_gap();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        detected = 1'b1;
        tick();
        detected = 1'b0;
        repeat (299) tick();
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd300 || ev_gap !== 8'd255) begin
            n_fail++;
            $display("FAIL t4_saturate got v=%0d ts=%0d gap=%0d required v=1 ts=300 gap=255",
                     ev_valid, ev_ts, ev_gap);
        end
        tick();
        detected = 1'b1;
        tick();
        en = 1'b0;
        repeat (50) tick();
        detected = 1'b0;
        en = 1'b1;
        repeat (19) tick();
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd322 || ev_gap !== 8'd20) begin
            n_fail++;
            $display("FAIL t4_en_gap got v=%0d ts=%0d gap=%0d required v=1 ts=322 gap=20",
                     ev_valid, ev_ts, ev_gap);
        end
        n_checks++;
        if (total_count !== 16'd4) begin
            n_fail++;
            $display("FAIL t4_total got %0d required 4", total_count);
        end
        tick();
    endtask

    task automatic test_clear();
        ev_ready = 1'b0;
        detected = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (fifo_level !== 3'd3 || total_count !== 16'd7) begin
            n_fail++;
            $display("FAIL t5_pre got lvl=%0d tot=%0d required lvl=3 tot=7", fifo_level, total_count);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b0 || fifo_level !== 3'd0 || total_count !== 16'd0 ||
            drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_cleared got v=%0d lvl=%0d tot=%0d drop=%0d ovf=%0d required all 0",
                     ev_valid, fifo_level, total_count, drop_count, overflow);
        end
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd0 || ev_gap !== 8'd255) begin
            n_fail++;
            $display("FAIL t5_next got v=%0d ts=%0d gap=%0d required v=1 ts=0 gap=255",
                     ev_valid, ev_ts, ev_gap);
        end
    endtask

    // Entered with one entry queued (ts=0) and ev_ready=0.
    task automatic test_async_reset();
        detected = 1'b1;
        repeat (2) tick();
        detected = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd3) begin
            n_fail++;
            $display("FAIL t6_pre got lvl=%0d required 3", fifo_level);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ev_valid, ev_ts, ev_gap, fifo_level, total_count,
             drop_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL t6_async got v=%0d ts=%0d gap=%0d lvl=%0d tot=%0d drop=%0d ovf=%0d required all 0",
                     ev_valid, ev_ts, ev_gap, fifo_level, total_count, drop_count, overflow);
        end
        repeat (2) tick();
        rst = 1'b0;
        detected = 1'b1;
        tick();
        detected = 1'b0;
        n_checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 16'd0 || ev_gap !== 8'd255 ||
            total_count !== 16'd1) begin
            n_fail++;
            $display("FAIL t6_restart got v=%0d ts=%0d gap=%0d tot=%0d required v=1 ts=0 gap=255 tot=1",
                     ev_valid, ev_ts, ev_gap, total_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_gap();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
